// File: rtl/video_out_timing_aligner.sv
// ---------------------------------------------------------------------------
// video_out_timing_aligner
//
// Video output front end between the frame-buffer read port and the TX.
// A free-running raster generator produces the raw request timing (fb_de,
// fb_vs_n) for the frame buffer. The raw de/hs/vs are delayed by the frame
// buffer read latency, so they line up with the returned pixels. The pixel
// source is then selected, the RGB565 data is expanded to RGB888, and
// everything is registered once more onto the output pins.
//
// Frame-buffer interface: this is a fixed-latency request/response, with no
// backpressure. The frame buffer must answer every fb_de=1 cycle with
// fb_den=1 and fb_data exactly LATENCY cycles later. If fb_den is low on a
// cycle where the delayed de is high, in camera mode, that is a read
// underflow. The flag is sticky, and the pixel is blanked to black.
//
// Parameters
//   H_ACTIVE/H_FP/H_SYNC/H_BP  horizontal timing in pixels
//   V_ACTIVE/V_FP/V_SYNC/V_BP  vertical timing in lines
//   HS_POL/VS_POL              out_hs/out_vs polarity (1 active-high, 0 active-low)
//   LATENCY                    fb_de -> fb_den/fb_data latency, must be >= 1
//   FCNT_W                     frame counter width
//
// Ports
//   video_clk      in   pixel clock
//   rst_n          in   asynchronous reset, active-low
//   mode[1:0]      in   0 camera, 1 colour bars, 2 solid, 3 black
//   solid_rgb[23:0]in   {r,g,b} used in mode 2
//   underflow_clr  in   clears the sticky underflow flag
//   fb_de          out  raw active-video request to the frame buffer
//   fb_vs_n        out  raw vsync to the frame buffer, always active-low
//   fb_den         in   frame-buffer data valid
//   fb_data[15:0]  in   frame-buffer pixel {r5,g6,b5}
//   out_hs/out_vs  out  aligned syncs, polarity per HS_POL/VS_POL
//   out_de         out  aligned data enable
//   out_r/g/b[7:0] out  RGB888 pixel, zero whenever out_de=0
//   frame_cnt      out  frames started since reset, wraps to 0
//   underflow      out  sticky underflow flag
// ---------------------------------------------------------------------------
module video_out_timing_aligner #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int LATENCY  = 7,
  parameter int FCNT_W   = 16
) (
  input  logic              video_clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic [23:0]       solid_rgb,
  input  logic              underflow_clr,
  output logic              fb_de,
  output logic              fb_vs_n,
  input  logic              fb_den,
  input  logic [15:0]       fb_data,
  output logic              out_hs,
  output logic              out_vs,
  output logic              out_de,
  output logic [7:0]        out_r,
  output logic [7:0]        out_g,
  output logic [7:0]        out_b,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              underflow
);

  // -------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The extra +1 lets a sync window end exactly at H_TOTAL/V_TOTAL when the
  // back porch is zero.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START_L = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_L   = HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START_L = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_L   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Colour bar width. The bar index saturates at 7, so any remainder pixels
  // (H_ACTIVE not divisible by 8) fall into the last, black bar.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  // -------------------------------------------------------------------------
  // Raster counters
  // -------------------------------------------------------------------------
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          frame_start;

  assign frame_start = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt <= '0;
      end else begin
        v_cnt <= v_cnt + VW'(1);
      end
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Raw stage: registered decode of the counters
  // -------------------------------------------------------------------------
  logic active_win;
  logic hs_win;
  logic vs_win;
  logic raw_hs;

  assign active_win = (h_cnt < H_ACT_L) && (v_cnt < V_ACT_L);
  assign hs_win     = (h_cnt >= HS_START_L) && (h_cnt < HS_END_L);
  assign vs_win     = (v_cnt >= VS_START_L) && (v_cnt < VS_END_L);

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_de   <= 1'b0;
      fb_vs_n <= 1'b1;
      raw_hs  <= 1'b0;
    end else begin
      fb_de   <= active_win;
      fb_vs_n <= ~vs_win;
      raw_hs  <= hs_win;
    end
  end

  // -------------------------------------------------------------------------
  // Mode register and frame counter, both updated at frame start
  // -------------------------------------------------------------------------
  logic [1:0] mode_r;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r    <= 2'd0;
      frame_cnt <= '0;
    end else if (frame_start) begin
      mode_r    <= mode;
      frame_cnt <= frame_cnt + FCNT_W'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Delay line: raw de/hs/vs shifted LATENCY stages (active-high internally)
  // -------------------------------------------------------------------------
  logic [LATENCY-1:0] de_sr;
  logic [LATENCY-1:0] hs_sr;
  logic [LATENCY-1:0] vs_sr;
  logic               d_de;
  logic               d_hs;
  logic               d_vs;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr[0] <= fb_de;
      hs_sr[0] <= raw_hs;
      vs_sr[0] <= ~fb_vs_n;
      for (int i = 1; i < LATENCY; i++) begin
        de_sr[i] <= de_sr[i-1];
        hs_sr[i] <= hs_sr[i-1];
        vs_sr[i] <= vs_sr[i-1];
      end
    end
  end

  assign d_de = de_sr[LATENCY-1];
  assign d_hs = hs_sr[LATENCY-1];
  assign d_vs = vs_sr[LATENCY-1];

  // -------------------------------------------------------------------------
  // Colour bar position, tracked on the delayed de so it lines up with the
  // pixel being emitted. It clears during blanking.
  // -------------------------------------------------------------------------
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [23:0]   bar_rgb;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= 3'd0;
    end else if (!d_de) begin
      bar_px  <= '0;
      bar_idx <= 3'd0;
    end else if (bar_px == BAR_LAST) begin
      bar_px <= '0;
      if (bar_idx != 3'd7) begin
        bar_idx <= bar_idx + 3'd1;
      end
    end else begin
      bar_px <= bar_px + BW'(1);
    end
  end

  // Bar order is white, yellow, cyan, green, magenta, red, blue, black:
  // red is on when idx[1]=0, green when idx[2]=0, blue when idx[0]=0.
  assign bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};

  // -------------------------------------------------------------------------
  // Pixel select and underflow detect
  // -------------------------------------------------------------------------
  logic [23:0] pix_next;
  logic [23:0] cam_rgb;
  logic        uf_hit;

  // Bit replication maps 0 to 00 and full scale to FF.
  assign cam_rgb = {fb_data[15:11], fb_data[15:13],
                    fb_data[10:5],  fb_data[10:9],
                    fb_data[4:0],   fb_data[4:2]};

  always_comb begin
    pix_next = 24'h000000;
    uf_hit   = 1'b0;
    if (d_de) begin
      case (mode_r)
        2'd0: begin
          if (fb_den) begin
            pix_next = cam_rgb;
          end else begin
            uf_hit = 1'b1;
          end
        end
        2'd1:    pix_next = bar_rgb;
        2'd2:    pix_next = solid_rgb;
        default: pix_next = 24'h000000;
      endcase
    end
  end

  // A set on the same cycle as a clear wins.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (uf_hit) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_de <= 1'b0;
      out_hs <= ~HS_POL;
      out_vs <= ~VS_POL;
      out_r  <= 8'h00;
      out_g  <= 8'h00;
      out_b  <= 8'h00;
    end else begin
      out_de <= d_de;
      out_hs <= HS_POL ? d_hs : ~d_hs;
      out_vs <= VS_POL ? d_vs : ~d_vs;
      out_r  <= pix_next[23:16];
      out_g  <= pix_next[15:8];
      out_b  <= pix_next[7:0];
    end
  end

endmodule

// File: tb/tb_video_out_timing_aligner.sv
// ---------------------------------------------------------------------------
// Testbench for video_out_timing_aligner (small raster: 24 x 8, latency 3).
// The reference model works from the cycle index since reset release and
// the recorded input history. It derives the expected raster position and
// pipeline offsets arithmetically, frame by frame.
// ---------------------------------------------------------------------------
module tb_video_out_timing_aligner;

  localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
  localparam int V_ACTIVE = 4,  V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL  = 24, V_TOTAL = 8, FRAME = H_TOTAL * V_TOTAL;
  localparam int LAT      = 3;
  localparam int FCNT_W   = 2;
  localparam int HMAX     = 8192;

  // ---------------- clock / reset ----------------
  logic video_clk;
  logic rst_n;

  initial video_clk = 1'b0;
  always #5 video_clk = ~video_clk;

  // ---------------- DUT signals ----------------
  logic [1:0]        mode;
  logic [23:0]       solid_rgb;
  logic              underflow_clr;
  logic              fb_de;
  logic              fb_vs_n;
  logic              fb_den;
  logic [15:0]       fb_data;
  logic              out_hs;
  logic              out_vs;
  logic              out_de;
  logic [7:0]        out_r;
  logic [7:0]        out_g;
  logic [7:0]        out_b;
  logic [FCNT_W-1:0] frame_cnt;
  logic              underflow;

  video_out_timing_aligner #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(1'b0), .VS_POL(1'b1), .LATENCY(LAT), .FCNT_W(FCNT_W)
  ) dut (
    .video_clk(video_clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .underflow_clr(underflow_clr), .fb_de(fb_de), .fb_vs_n(fb_vs_n),
    .fb_den(fb_den), .fb_data(fb_data), .out_hs(out_hs), .out_vs(out_vs),
    .out_de(out_de), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .frame_cnt(frame_cnt), .underflow(underflow)
  );

  // ---------------- frame-buffer model ----------------
  // It returns data valid exactly LAT cycles after each request. drop masks
  // a single cycle.
  logic [LAT-1:0] fb_sr;
  logic           drop;

  always @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) fb_sr <= '0;
    else        fb_sr <= {fb_sr[LAT-2:0], fb_de};
  end

  assign fb_den = fb_sr[LAT-1] & ~drop;

  // ---------------- observed vectors ----------------
  logic [4:0]  obs_t;
  logic [23:0] obs_p;
  logic [2:0]  obs_s;
  assign obs_t = {fb_de, fb_vs_n, out_de, out_hs, out_vs};
  assign obs_p = {out_r, out_g, out_b};
  assign obs_s = {frame_cnt, underflow};

  // ---------------- input history + underflow model ----------------
  int          cyc;
  logic        exp_uf;
  logic [1:0]  mode_h  [HMAX];
  logic        den_h   [HMAX];
  logic [15:0] data_h  [HMAX];
  logic [23:0] solid_h [HMAX];

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  function automatic int hpos(int k);
    return k % H_TOTAL;
  endfunction

  function automatic int vpos(int k);
    return (k / H_TOTAL) % V_TOTAL;
  endfunction

  function automatic bit active_at(int k);
    return (k >= 0) && (hpos(k) < H_ACTIVE) && (vpos(k) < V_ACTIVE);
  endfunction

  function automatic bit hs_at(int k);
    return (k >= 0) && (hpos(k) >= H_ACTIVE + H_FP) && (hpos(k) < H_ACTIVE + H_FP + H_SYNC);
  endfunction

  function automatic bit vs_at(int k);
    return (k >= 0) && (vpos(k) >= V_ACTIVE + V_FP) && (vpos(k) < V_ACTIVE + V_FP + V_SYNC);
  endfunction

  // The mode used for a pixel is whatever was applied at the start of that
  // pixel's frame. j is the cycle in which the pixel reaches the select stage.
  function automatic logic [1:0] pix_mode(int j);
    int k;
    k = j - LAT - 1;
    if (k < 0) return 2'd0;
    return mode_h[(k / FRAME) * FRAME];
  endfunction

  function automatic logic [23:0] rgb888(logic [15:0] d);
    int r5, g6, b5;
    r5 = int'(d[15:11]);
    g6 = int'(d[10:5]);
    b5 = int'(d[4:0]);
    return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
  endfunction

  // {fb_de, fb_vs_n, out_de, out_hs(active-low), out_vs(active-high)} in cycle m
  function automatic logic [4:0] exp_timing(int m);
    logic [4:0] r;
    r[4] = active_at(m - 1);
    r[3] = !vs_at(m - 1);
    r[2] = active_at(m - LAT - 2);
    r[1] = !hs_at(m - LAT - 2);
    r[0] = vs_at(m - LAT - 2);
    return r;
  endfunction

  function automatic logic [23:0] exp_pixel(int m);
    int j, x;
    j = m - 1;
    if (j < 0 || !active_at(j - LAT - 1)) return 24'h0;
    case (pix_mode(j))
      2'd0: return den_h[j] ? rgb888(data_h[j]) : 24'h0;
      2'd1: begin
        x = hpos(j - LAT - 1) / (H_ACTIVE / 8);
        if (x > 7) x = 7;
        return bars[x];
      end
      2'd2:    return solid_h[j];
      default: return 24'h0;
    endcase
  endfunction

  function automatic logic [2:0] exp_status(int m);
    int fc;
    fc = (m == 0) ? 0 : ((m - 1) / FRAME + 1) % (1 << FCNT_W);
    return {2'(fc), exp_uf};
  endfunction

  always @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc    <= 0;
      exp_uf <= 1'b0;
    end else begin
      if (cyc < HMAX) begin
        mode_h[cyc]  <= mode;
        den_h[cyc]   <= fb_den;
        data_h[cyc]  <= fb_data;
        solid_h[cyc] <= solid_rgb;
      end
      if (active_at(cyc - LAT - 1) && !fb_den && pix_mode(cyc) == 2'd0) exp_uf <= 1'b1;
      else if (underflow_clr)                                           exp_uf <= 1'b0;
      cyc <= cyc + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; mode = 2'd0; solid_rgb = 24'h0; underflow_clr = 1'b0;
    fb_data = 16'h0; drop = 1'b0;
    repeat (3) @(negedge video_clk);
    n_checks++;
    if (obs_t !== 5'b01010) begin n_err++; $display("FAIL reset_timing got=%b exp=%b", obs_t, 5'b01010); end
    n_checks++;
    if (obs_p !== 24'h0) begin n_err++; $display("FAIL reset_pixel got=%h exp=%h", obs_p, 24'h0); end
    n_checks++;
    if (obs_s !== 3'b000) begin n_err++; $display("FAIL reset_status got=%b exp=%b", obs_s, 3'b000); end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (obs_t !== exp_timing(cyc)) begin n_err++; $display("FAIL release_timing cyc=%0d got=%b exp=%b", cyc, obs_t, exp_timing(cyc)); end
  endtask

  task automatic test_free_run();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge video_clk);
      n_checks++;
      if (obs_t !== exp_timing(cyc)) begin n_err++; $display("FAIL free_run_timing cyc=%0d got=%b exp=%b", cyc, obs_t, exp_timing(cyc)); end
      n_checks++;
      if (obs_p !== exp_pixel(cyc)) begin n_err++; $display("FAIL free_run_pixel cyc=%0d got=%h exp=%h", cyc, obs_p, exp_pixel(cyc)); end
      n_checks++;
      if (obs_s !== exp_status(cyc)) begin n_err++; $display("FAIL free_run_status cyc=%0d got=%b exp=%b", cyc, obs_s, exp_status(cyc)); end
      fb_data = 16'($urandom);
    end
  endtask

  task automatic test_mode0_red();
    fb_data = 16'hF800;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge video_clk);
      n_checks++;
      if (obs_p !== exp_pixel(cyc)) begin n_err++; $display("FAIL red_pixel cyc=%0d got=%h exp=%h", cyc, obs_p, exp_pixel(cyc)); end
      n_checks++;
      if (out_de && obs_p !== 24'hFF0000) begin n_err++; $display("FAIL red_value cyc=%0d got=%h exp=%h", cyc, obs_p, 24'hFF0000); end
      n_checks++;
      if (obs_s !== exp_status(cyc)) begin n_err++; $display("FAIL red_status cyc=%0d got=%b exp=%b", cyc, obs_s, exp_status(cyc)); end
    end
  endtask

  task automatic test_underflow();
    int  phase;
    bit  pend;
    logic pend_val;
    phase = 0; pend = 1'b0; pend_val = 1'b0;
    for (int t = 0; t < 2 * FRAME; t++) begin
      @(negedge video_clk);
      n_checks++;
      if (obs_p !== exp_pixel(cyc)) begin n_err++; $display("FAIL uf_pixel cyc=%0d got=%h exp=%h", cyc, obs_p, exp_pixel(cyc)); end
      n_checks++;
      if (obs_s !== exp_status(cyc)) begin n_err++; $display("FAIL uf_status cyc=%0d got=%b exp=%b", cyc, obs_s, exp_status(cyc)); end
      if (pend) begin
        n_checks++;
        if (underflow !== pend_val) begin n_err++; $display("FAIL uf_flag phase=%0d got=%b exp=%b", phase, underflow, pend_val); end
        pend = 1'b0;
      end
      drop = 1'b0; underflow_clr = 1'b0;
      fb_data = 16'($urandom);
      if (phase == 0 && t >= 10 && fb_sr[LAT-1]) begin
        drop = 1'b1; phase = 1; pend = 1'b1; pend_val = 1'b1;
      end else if (phase == 1 && t == 120) begin
        underflow_clr = 1'b1; phase = 2; pend = 1'b1; pend_val = 1'b0;
      end else if (phase == 2 && t >= 200 && fb_sr[LAT-1]) begin
        drop = 1'b1; underflow_clr = 1'b1; phase = 3; pend = 1'b1; pend_val = 1'b1;
      end
    end
    drop = 1'b0; underflow_clr = 1'b0;
    n_checks++;
    if (phase != 3) begin n_err++; $display("FAIL uf_sequence phase=%0d exp=%0d", phase, 3); end
  endtask

  task automatic test_bars();
    mode = 2'd1;
    underflow_clr = 1'b1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      @(negedge video_clk);
      n_checks++;
      if (obs_t !== exp_timing(cyc)) begin n_err++; $display("FAIL bars_timing cyc=%0d got=%b exp=%b", cyc, obs_t, exp_timing(cyc)); end
      n_checks++;
      if (obs_p !== exp_pixel(cyc)) begin n_err++; $display("FAIL bars_pixel cyc=%0d got=%h exp=%h", cyc, obs_p, exp_pixel(cyc)); end
      n_checks++;
      if (obs_s !== exp_status(cyc)) begin n_err++; $display("FAIL bars_status cyc=%0d got=%b exp=%b", cyc, obs_s, exp_status(cyc)); end
      underflow_clr = 1'b0;
      fb_data = 16'($urandom);
      drop = ($urandom_range(0, 7) == 0);
    end
    drop = 1'b0;
  endtask

  task automatic test_mode_switch();
    bit seen_start, switched;
    int cnt_after;
    seen_start = 1'b0; switched = 1'b0; cnt_after = 0;
    mode = 2'd2;
    solid_rgb = 24'($urandom);
    for (int i = 0; i < 6 * FRAME && cnt_after < 2 * FRAME; i++) begin
      @(negedge video_clk);
      n_checks++;
      if (obs_t !== exp_timing(cyc)) begin n_err++; $display("FAIL switch_timing cyc=%0d got=%b exp=%b", cyc, obs_t, exp_timing(cyc)); end
      n_checks++;
      if (obs_p !== exp_pixel(cyc)) begin n_err++; $display("FAIL switch_pixel cyc=%0d got=%h exp=%h", cyc, obs_p, exp_pixel(cyc)); end
      n_checks++;
      if (obs_s !== exp_status(cyc)) begin n_err++; $display("FAIL switch_status cyc=%0d got=%b exp=%b", cyc, obs_s, exp_status(cyc)); end
      fb_data = 16'($urandom);
      drop = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 7) == 0) solid_rgb = 24'($urandom);
      if (hpos(cyc) == 0 && vpos(cyc) == 0) seen_start = 1'b1;
      if (!switched && seen_start && hpos(cyc) == 5 && vpos(cyc) == 1) begin
        mode = 2'd3; switched = 1'b1;
      end
      if (switched) cnt_after++;
    end
    drop = 1'b0;
    n_checks++;
    if (!switched) begin n_err++; $display("FAIL switch_reached got=%0d exp=%0d", switched, 1); end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    mode = 2'd0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge video_clk);
      if (hpos(cyc) == 7 && vpos(cyc) == 1) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_err++; $display("FAIL rst_mid_position got=%0d exp=%0d", found, 1); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs_t !== 5'b01010) begin n_err++; $display("FAIL rst_mid_timing got=%b exp=%b", obs_t, 5'b01010); end
    n_checks++;
    if (obs_p !== 24'h0) begin n_err++; $display("FAIL rst_mid_pixel got=%h exp=%h", obs_p, 24'h0); end
    n_checks++;
    if (obs_s !== 3'b000) begin n_err++; $display("FAIL rst_mid_status got=%b exp=%b", obs_s, 3'b000); end
    repeat (2) @(negedge video_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME + 8; i++) begin
      @(negedge video_clk);
      n_checks++;
      if (obs_t !== exp_timing(cyc)) begin n_err++; $display("FAIL rst_mid_run_timing cyc=%0d got=%b exp=%b", cyc, obs_t, exp_timing(cyc)); end
      n_checks++;
      if (obs_p !== exp_pixel(cyc)) begin n_err++; $display("FAIL rst_mid_run_pixel cyc=%0d got=%h exp=%h", cyc, obs_p, exp_pixel(cyc)); end
      n_checks++;
      if (obs_s !== exp_status(cyc)) begin n_err++; $display("FAIL rst_mid_run_status cyc=%0d got=%b exp=%b", cyc, obs_s, exp_status(cyc)); end
      if (cyc <= LAT + 1) begin
        n_checks++;
        if (out_de !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_de cyc=%0d got=%b exp=%b", cyc, out_de, 1'b0); end
      end
      fb_data = 16'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_mode0_red();
    test_underflow();
    test_bars();
    test_mode_switch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
